// File: rtl/bcd_display_feed.sv
// ----------------------------------------------------------------------------
// bcd_display_feed
//   Feeds the 4-digit display monitor. It takes a binary value, clamps it to
//   0..9999 and converts it to packed BCD using an iterative shift-add-3
//   (double-dabble) engine. Display updates are rate-limited by a free-running
//   refresh timer so the monitor does not flicker.
//
// Ports
//   clk        system clock (same clock as the monitor)
//   rst        asynchronous, active-high reset
//   bin_in     binary value to display (BIN_W bits)
//   bin_valid  bin_in is valid
//   bin_ready  block accepts bin_in this cycle (high only in IDLE)
//   num        packed BCD {thousands, hundreds, tens, ones}
//   num_valid  one-cycle pulse when num is updated
//   overflow   last accepted value exceeded 9999 (num then shows 9999)
// ----------------------------------------------------------------------------
module bcd_display_feed #(
    parameter int BIN_W          = 16,
    parameter int REFRESH_CYCLES = 25_000_000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [BIN_W-1:0] bin_in,
    input  logic             bin_valid,
    output logic             bin_ready,
    output logic [15:0]      num,
    output logic             num_valid,
    output logic             overflow
);

    localparam int CNT_W = (REFRESH_CYCLES > 2) ? $clog2(REFRESH_CYCLES) : 1;
    localparam int STEPS = 14;

    typedef enum logic [1:0] {
        IDLE,
        CONVERT,
        DONE,
        HOLD
    } state_t;

    state_t      state_q;
    logic [CNT_W-1:0] cnt_q;
    logic        tick;
    logic [13:0] v_q;
    logic [15:0] bcd_q;
    logic [3:0]  step_q;
    logic        ovf_pend_q;
    logic [15:0] num_q;
    logic        num_valid_q;
    logic        overflow_q;

    // Clamp decision uses the full input width so any set bit above 13
    // (or any value 10000..16383) saturates to 9999.
    logic        clamp_c;
    logic [13:0] v_in;
    assign clamp_c = (bin_in > BIN_W'(9999));
    assign v_in    = clamp_c ? 14'd9999 : bin_in[13:0];

    // ------------------------------------------------------------------
    // Refresh timer: free-running, tick on the terminal count.
    // ------------------------------------------------------------------
    assign tick = (cnt_q == CNT_W'(REFRESH_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Double-dabble step: each nibble >= 5 gets +3, then {bcd, v} << 1.
    // The thousands nibble never exceeds 9 for inputs <= 9999, so the bit
    // shifted out of bcd[15] is always zero and can be dropped.
    // ------------------------------------------------------------------
    logic [15:0] bcd_adj;
    logic [15:0] bcd_d;
    logic [13:0] v_d;

    for (genvar gi = 0; gi < 4; gi++) begin : g_adj
        assign bcd_adj[4*gi +: 4] = (bcd_q[4*gi +: 4] >= 4'd5) ?
                                    (bcd_q[4*gi +: 4] + 4'd3) :
                                    bcd_q[4*gi +: 4];
    end

    assign bcd_d = {bcd_adj[14:0], v_q[13]};
    assign v_d   = {v_q[12:0], 1'b0};

    // ------------------------------------------------------------------
    // Control FSM with registered outputs.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            v_q         <= '0;
            bcd_q       <= '0;
            step_q      <= '0;
            ovf_pend_q  <= 1'b0;
            num_q       <= '0;
            num_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            num_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bin_valid) begin
                        v_q        <= v_in;
                        ovf_pend_q <= clamp_c;
                        bcd_q      <= '0;
                        step_q     <= '0;
                        state_q    <= CONVERT;
                    end
                end
                CONVERT: begin
                    bcd_q  <= bcd_d;
                    v_q    <= v_d;
                    step_q <= step_q + 4'd1;
                    if (step_q == 4'(STEPS - 1)) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    num_q       <= bcd_q;
                    overflow_q  <= ovf_pend_q;
                    num_valid_q <= 1'b1;
                    state_q     <= HOLD;
                end
                HOLD: begin
                    // Only a tick seen while waiting here releases the block;
                    // earlier ticks are deliberately forgotten.
                    if (tick) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bin_ready = (state_q == IDLE);
    assign num       = num_q;
    assign num_valid = num_valid_q;
    assign overflow  = overflow_q;

endmodule
